// File: rtl/pid_mux_ctrl.sv
// pid_mux_ctrl: time-multiplexed P/I/D term engine for NUM_AXES axes.
// One shared multiplier is sequenced per axis through the P, I and D states.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   vld, en             new reading strobe and engine enable
//   actual, desired     packed signed 16-bit angles, axis i at [16i+15:16i]
//   kp, ki, kd          live unsigned 6-bit gains
//   int_clr             clear all integrators
//   busy, out_vld, ovr  status, result strobe, dropped-reading pulse
//   out_term            packed signed OUT_W-bit P+I+D terms per axis
module pid_mux_ctrl #(
  parameter int NUM_AXES      = 3,
  parameter int ERR_W         = 10,
  parameter int D_QUEUE_DEPTH = 14,
  parameter int D_DIFF_W      = 7,
  parameter int I_ACC_W       = 16,
  parameter int I_SHIFT       = 6,
  parameter int OUT_W         = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld,
  input  logic                      en,
  input  logic [16*NUM_AXES-1:0]    actual,
  input  logic [16*NUM_AXES-1:0]    desired,
  input  logic [5:0]                kp,
  input  logic [5:0]                ki,
  input  logic [5:0]                kd,
  input  logic                      int_clr,
  output logic                      busy,
  output logic                      out_vld,
  output logic [OUT_W*NUM_AXES-1:0] out_term,
  output logic                      ovr
);

  localparam int AXW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int OPW = (I_ACC_W >= ERR_W) ?
                       ((I_ACC_W >= D_DIFF_W) ? I_ACC_W : D_DIFF_W) :
                       ((ERR_W >= D_DIFF_W) ? ERR_W : D_DIFF_W);
  localparam int PW  = OPW + 7;
  localparam int SW  = PW + 2;

  localparam logic signed [16:0] E_HI =
    17'((1 <<< (ERR_W - 1)) - 1);
  localparam logic signed [16:0] E_LO =
    17'(-(1 <<< (ERR_W - 1)));
  localparam logic signed [I_ACC_W:0] A_HI =
    (I_ACC_W+1)'((1 <<< (I_ACC_W - 1)) - 1);
  localparam logic signed [I_ACC_W:0] A_LO =
    (I_ACC_W+1)'(-(1 <<< (I_ACC_W - 1)));
  localparam logic signed [ERR_W:0] DF_HI =
    (ERR_W+1)'((1 <<< (D_DIFF_W - 1)) - 1);
  localparam logic signed [ERR_W:0] DF_LO =
    (ERR_W+1)'(-(1 <<< (D_DIFF_W - 1)));
  localparam logic signed [SW-1:0] O_HI =
    SW'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] O_LO =
    SW'(-(1 <<< (OUT_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_P, S_I, S_D, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [AXW-1:0] ax_q, ax_d;

  logic signed [15:0]        act_q  [NUM_AXES];
  logic signed [15:0]        des_q  [NUM_AXES];
  logic signed [I_ACC_W-1:0] acc_q  [NUM_AXES];
  logic signed [ERR_W-1:0]   hist_q [NUM_AXES][D_QUEUE_DEPTH];
  logic signed [OUT_W-1:0]   shad_q [NUM_AXES];
  logic signed [OUT_W-1:0]   term_q [NUM_AXES];
  logic signed [PW-1:0]      p_q, i_q;
  logic                      out_vld_q, ovr_q;

  logic signed [16:0]        err_w;
  logic signed [ERR_W-1:0]   err_sat;
  logic signed [I_ACC_W:0]   acc_w;
  logic signed [I_ACC_W-1:0] acc_sat;
  logic signed [ERR_W:0]     diff_w;
  logic signed [D_DIFF_W-1:0] diff_sat;
  logic [5:0]                gain;
  logic signed [OPW-1:0]     opnd;
  logic signed [PW-1:0]      prod;
  logic signed [SW-1:0]      sum_w;
  logic signed [OUT_W-1:0]   sum_sat;

  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    case (state_q)
      S_IDLE: begin
        if (vld && en) begin
          state_d = S_P;
          ax_d    = '0;
        end
      end
      S_P: state_d = S_I;
      S_I: state_d = S_D;
      S_D: begin
        if (ax_q == AXW'(NUM_AXES - 1)) begin
          state_d = S_DONE;
        end else begin
          ax_d    = ax_q + AXW'(1);
          state_d = S_P;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath for the axis currently selected by ax_q.
  always_comb begin
    err_w = $signed({act_q[ax_q][15], act_q[ax_q]})
          - $signed({des_q[ax_q][15], des_q[ax_q]});
    if (err_w > E_HI)      err_sat = ERR_W'(E_HI);
    else if (err_w < E_LO) err_sat = ERR_W'(E_LO);
    else                   err_sat = ERR_W'(err_w);

    acc_w = (I_ACC_W+1)'(acc_q[ax_q]) + (I_ACC_W+1)'(err_sat);
    if (acc_w > A_HI)      acc_sat = I_ACC_W'(A_HI);
    else if (acc_w < A_LO) acc_sat = I_ACC_W'(A_LO);
    else                   acc_sat = I_ACC_W'(acc_w);

    diff_w = (ERR_W+1)'(err_sat)
           - (ERR_W+1)'(hist_q[ax_q][D_QUEUE_DEPTH-1]);
    if (diff_w > DF_HI)      diff_sat = D_DIFF_W'(DF_HI);
    else if (diff_w < DF_LO) diff_sat = D_DIFF_W'(DF_LO);
    else                     diff_sat = D_DIFF_W'(diff_w);

    gain = 6'd0;
    opnd = '0;
    case (state_q)
      S_P: begin
        gain = kp;
        opnd = OPW'(err_sat);
      end
      S_I: begin
        gain = ki;
        opnd = OPW'(acc_sat);
      end
      S_D: begin
        gain = kd;
        opnd = OPW'(diff_sat);
      end
      default: ;
    endcase
    prod = PW'($signed({1'b0, gain})) * PW'(opnd);

    // In D the multiplier output is the D term itself.
    sum_w = SW'(p_q) + SW'(i_q) + SW'(prod);
    if (sum_w > O_HI)      sum_sat = OUT_W'(O_HI);
    else if (sum_w < O_LO) sum_sat = OUT_W'(O_LO);
    else                   sum_sat = OUT_W'(sum_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ax_q      <= '0;
      p_q       <= '0;
      i_q       <= '0;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      for (int a = 0; a < NUM_AXES; a++) begin
        act_q[a]  <= '0;
        des_q[a]  <= '0;
        acc_q[a]  <= '0;
        shad_q[a] <= '0;
        term_q[a] <= '0;
        for (int j = 0; j < D_QUEUE_DEPTH; j++)
          hist_q[a][j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ax_q      <= ax_d;
      out_vld_q <= (state_q == S_DONE);
      ovr_q     <= vld && (state_q != S_IDLE);

      if (state_q == S_IDLE && vld && en) begin
        for (int a = 0; a < NUM_AXES; a++) begin
          act_q[a] <= actual[16*a +: 16];
          des_q[a] <= desired[16*a +: 16];
        end
      end

      if (state_q == S_P)
        p_q <= prod >>> 3;

      if (state_q == S_I) begin
        i_q         <= prod >>> I_SHIFT;
        acc_q[ax_q] <= acc_sat;
      end

      // Placed after the I update so the clear takes priority.
      if (int_clr) begin
        for (int a = 0; a < NUM_AXES; a++)
          acc_q[a] <= '0;
      end

      if (state_q == S_D) begin
        shad_q[ax_q] <= sum_sat;
        for (int j = D_QUEUE_DEPTH - 1; j > 0; j--)
          hist_q[ax_q][j] <= hist_q[ax_q][j-1];
        hist_q[ax_q][0] <= err_sat;
      end

      if (state_q == S_DONE) begin
        for (int a = 0; a < NUM_AXES; a++)
          term_q[a] <= shad_q[a];
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign out_vld = out_vld_q;
  assign ovr     = ovr_q;

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_out
    assign out_term[OUT_W*a +: OUT_W] = term_q[a];
  end

endmodule

// File: tb/tb_pid_mux_ctrl.sv
// tb_pid_mux_ctrl: randomized and directed self-check of pid_mux_ctrl
// against a behavioural per-axis PID model.
module tb_pid_mux_ctrl;
  localparam int N  = 3;
  localparam int OW = 12;
  localparam int DQ = 14;

  logic clk = 1'b0;
  logic rst, vld, en, int_clr;
  logic [16*N-1:0] actual, desired;
  logic [5:0] kp, ki, kd;
  logic busy, out_vld, ovr;
  logic [OW*N-1:0] out_term;

  int n_pass = 0;
  int n_chk  = 0;
  int a_act [N];
  int a_des [N];
  int exp_t [N];
  int got_t [N];
  int m_acc [N];
  int m_hist [N][DQ];

  always #5 clk = ~clk;

  pid_mux_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .en       (en),
    .actual   (actual),
    .desired  (desired),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .int_clr  (int_clr),
    .busy     (busy),
    .out_vld  (out_vld),
    .out_term (out_term),
    .ovr      (ovr)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < N; a++) begin
      m_acc[a] = 0;
      for (int j = 0; j < DQ; j++) m_hist[a][j] = 0;
    end
  endtask

  // m_hist[a][0] is the newest error, m_hist[a][DQ-1] the oldest.
  task automatic model_frame();
    int e, p, i, df, d;
    for (int a = 0; a < N; a++) begin
      e = sat(a_act[a] - a_des[a], -512, 511);
      p = (int'(kp) * e) >>> 3;
      m_acc[a] = sat(m_acc[a] + e, -32768, 32767);
      i = (int'(ki) * m_acc[a]) >>> 6;
      df = sat(e - m_hist[a][DQ-1], -64, 63);
      d = int'(kd) * df;
      for (int j = DQ - 1; j > 0; j--) m_hist[a][j] = m_hist[a][j-1];
      m_hist[a][0] = e;
      exp_t[a] = sat(p + i + d, -2048, 2047);
    end
  endtask

  task automatic drive_inputs();
    for (int a = 0; a < N; a++) begin
      actual[16*a +: 16]  = 16'(a_act[a]);
      desired[16*a +: 16] = 16'(a_des[a]);
    end
  endtask

  task automatic read_terms();
    for (int a = 0; a < N; a++)
      got_t[a] = int'($signed(out_term[OW*a +: OW]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge; returns at a negedge with the bench idle.
  task automatic run_frame(input bit inj);
    int cyc, busy_n, ovr_n;
    drive_inputs();
    vld = 1'b1;
    cyc = 0;
    busy_n = 0;
    ovr_n = 0;
    model_frame();
    do begin
      @(negedge clk);
      cyc++;
      vld = inj && (cyc == 3);
      if (inj && cyc == 3) actual = ~actual;
      busy_n += int'(busy);
      ovr_n += int'(ovr);
    end while (!out_vld && cyc < 40);
    check("latency", cyc, 3*N + 2);
    check("busy_cycles", busy_n, 3*N + 1);
    check("ovr_count", ovr_n, inj ? 1 : 0);
    read_terms();
    for (int a = 0; a < N; a++)
      check($sformatf("term%0d", a), got_t[a], exp_t[a]);
    @(negedge clk);
    check("out_vld_pulse", int'(out_vld), 0);
  endtask

  task automatic set_err(input int e0, input int e1, input int e2);
    a_act[0] = e0; a_des[0] = 0;
    a_act[1] = e1; a_des[1] = 0;
    a_act[2] = e2; a_des[2] = 0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    vld = 1'b0;
    en = 1'b1;
    int_clr = 1'b0;
    actual = '0;
    desired = '0;
    kp = '0; ki = '0; kd = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_ovr", int'(ovr), 0);
    read_terms();
    for (int a = 0; a < N; a++)
      check($sformatf("rst_term%0d", a), got_t[a], 0);

    // Basic P term.
    kp = 6'd5;
    set_err(100, 0, 0);
    run_frame(1'b0);
    check("p_basic", got_t[0], 62);
    check("p_basic_ax1", got_t[1], 0);

    // Error saturation at the 16-bit extremes.
    a_act[0] = 32767; a_des[0] = -32768;
    run_frame(1'b0);
    check("p_sat_hi", got_t[0], 319);
    a_act[0] = -32768; a_des[0] = 32767;
    run_frame(1'b0);
    check("p_sat_lo", got_t[0], -320);

    // Derivative history window.
    do_reset();
    kp = 0; ki = 0; kd = 6'd7;
    set_err(20, 0, 0);
    for (int f = 1; f <= 15; f++) begin
      run_frame(1'b0);
      if (f == 1)  check("d_frame1", got_t[0], 140);
      if (f == 14) check("d_frame14", got_t[0], 140);
      if (f == 15) check("d_frame15", got_t[0], 0);
    end
    do_reset();
    set_err(200, 0, 0);
    run_frame(1'b0);
    check("d_diff_clamp", got_t[0], 441);

    // Integrator, clear and anti-windup.
    do_reset();
    kp = 0; ki = 6'd64 - 6'd1; kd = 0;
    ki = 6'd63;
    set_err(10, 0, 0);
    run_frame(1'b0);
    check("i_ki63", got_t[0], 9);
    do_reset();
    kd = 0;
    for (int f = 1; f <= 5; f++) begin
      ki = 6'd0;
      // ki=64 does not fit 6 bits; emulate 64 via two-frame split is
      // not possible, so use ki=32 and compare half values.
      ki = 6'd32;
      run_frame(1'b0);
      check($sformatf("i_ramp%0d", f), got_t[0], 5 * f);
    end
    int_clr = 1'b1;
    @(negedge clk);
    int_clr = 1'b0;
    model_reset();
    for (int a = 0; a < N; a++)
      for (int j = 0; j < DQ; j++) m_hist[a][j] = (a == 0) ? 10 : 0;
    run_frame(1'b0);
    check("i_after_clr", got_t[0], 5);
    ki = 6'd63;
    set_err(511, 0, 0);
    for (int f = 0; f < 200; f++) run_frame(1'b0);
    check("i_windup", got_t[0], 2047);

    // Output saturation both ways.
    do_reset();
    kp = 6'd63; ki = 0; kd = 6'd63;
    set_err(511, 0, 0);
    run_frame(1'b0);
    check("sat_pos", got_t[0], 2047);
    do_reset();
    set_err(-512, 0, 0);
    run_frame(1'b0);
    check("sat_neg", got_t[0], -2048);

    // Overrun: a second vld inside the frame.
    kp = 6'd5; kd = 0;
    set_err(100, -40, 7);
    run_frame(1'b1);

    // Engine disabled: vld ignored without ovr.
    en = 1'b0;
    vld = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      vld = 1'b0;
      cnt += int'(busy) + int'(ovr) + int'(out_vld);
    end
    check("en_low_idle", cnt, 0);
    en = 1'b1;

    // Reset in the middle of a frame.
    set_err(300, 0, 0);
    drive_inputs();
    vld = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vld = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    read_terms();
    check("midrst_term0", got_t[0], 0);
    check("midrst_term1", got_t[1], 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      cnt += int'(out_vld);
    end
    check("midrst_no_vld", cnt, 0);
    run_frame(1'b0);

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      kp = 6'($urandom_range(0, 63));
      ki = 6'($urandom_range(0, 63));
      kd = 6'($urandom_range(0, 63));
      for (int a = 0; a < N; a++) begin
        if ($urandom_range(0, 3) == 0) begin
          a_act[a] = int'($urandom_range(0, 65535)) - 32768;
          a_des[a] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          a_act[a] = int'($urandom_range(0, 600)) - 300;
          a_des[a] = int'($urandom_range(0, 200)) - 100;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        int_clr = 1'b1;
        @(negedge clk);
        int_clr = 1'b0;
        for (int a = 0; a < N; a++) m_acc[a] = 0;
      end
      run_frame($urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
